uart_number_reporter: RTL

Serial transmitter that reports the stopwatch count to the host over the USB-UART line (usb_tx). On a send pulse it snapshots the packed digit bus and transmits one ASCII character per digit, most-significant digit first, followed by CR LF. It uses 8N1 framing, LSB first. It sits beside the display driver and takes the same number bus from the counter module; in the top level it replaces the usb_rx-to-usb_tx loopback.

---
 rtl/uart_number_reporter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_number_reporter.sv
// Reports the packed digit bus over an 8N1 UART line as ASCII hex digits
// (most-significant first) followed by CR LF, one report per accepted send.
module uart_number_reporter #(
  parameter int unsigned NUMBER_OF_DIGITS            = 4,
  parameter int unsigned NUMBER_OF_BITS_PER_DIGIT    = 4,
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE                   = 115_200
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 send,
  input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
  output logic                                                 busy,
  output logic                                                 usb_tx
);

  localparam int unsigned CLKS_PER_BIT = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned NUM_CHARS    = NUMBER_OF_DIGITS + 2;
  localparam int unsigned IDX_W        = (NUM_CHARS > 2) ? $clog2(NUM_CHARS) : 1;
  localparam int unsigned NUM_W        = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [IDX_W-1:0] char_idx, char_idx_next;
  logic [NUM_W-1:0] snapshot, snapshot_next;
  logic             tx_next, busy_next;
  logic [3:0]       nibble;
  logic [7:0]       char_byte;
  logic             cnt_done;

  // Character index 0 maps to the most-significant digit; the last two are CR LF.
  always_comb begin
    nibble = '0;
    for (int unsigned i = 0; i < NUMBER_OF_DIGITS; i++) begin
      if (char_idx == IDX_W'(NUMBER_OF_DIGITS - 1 - i))
        nibble = 4'(snapshot[i*NUMBER_OF_BITS_PER_DIGIT +: NUMBER_OF_BITS_PER_DIGIT]);
    end
  end

  always_comb begin
    if (char_idx == IDX_W'(NUM_CHARS - 2))
      char_byte = 8'h0D;
    else if (char_idx == IDX_W'(NUM_CHARS - 1))
      char_byte = 8'h0A;
    else if (nibble <= 4'd9)
      char_byte = 8'h30 + {4'h0, nibble};
    else
      char_byte = 8'h37 + {4'h0, nibble};
  end

  assign cnt_done = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      snapshot <= '0;
      usb_tx   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bit_idx  <= bit_idx_next;
      char_idx <= char_idx_next;
      snapshot <= snapshot_next;
      usb_tx   <= tx_next;
      busy     <= busy_next;
    end
  end

  // Outputs are computed one cycle ahead so the line level changes on the
  // same edge as the state transition that owns it.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    bit_idx_next  = bit_idx;
    char_idx_next = char_idx;
    snapshot_next = snapshot;
    tx_next       = usb_tx;
    busy_next     = busy;
    unique case (state)
      IDLE: begin
        tx_next      = 1'b1;
        busy_next    = 1'b0;
        cnt_next     = '0;
        bit_idx_next = '0;
        if (send) begin
          snapshot_next = number;
          char_idx_next = '0;
          state_next    = START;
          tx_next       = 1'b0;
          busy_next     = 1'b1;
        end
      end
      START: begin
        if (cnt_done) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = DATA;
          tx_next      = char_byte[0];
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_done) begin
          cnt_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            tx_next      = char_byte[bit_idx + 3'd1];
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_done) begin
          cnt_next   = '0;
          state_next = NEXT;
          tx_next    = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      NEXT: begin
        cnt_next = '0;
        if (char_idx == IDX_W'(NUM_CHARS - 1)) begin
          state_next = IDLE;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
        end else begin
          char_idx_next = char_idx + IDX_W'(1);
          state_next    = START;
          tx_next       = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule
